mac_rx_frame_buffer: RTL and testbench



---
 rtl/mac_rx_frame_buffer_if.sv | 44 ++++
 rtl/mac_rx_frame_buffer.sv | 143 ++++++++++++++
 tb/tb_mac_rx_frame_buffer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_rx_frame_buffer_if.sv
// Bundles the MAC AXI-Stream RX beats and the RX_FIFO read pipe of the frame buffer.
// master = MAC/NIC side that sources beats and requests words; slave = the buffer itself.
interface mac_rx_frame_buffer_if #(
  parameter int MAC_WIDTH   = 64,
  parameter int TKEEP_WIDTH = MAC_WIDTH / 8,
  parameter int NIC_WIDTH   = MAC_WIDTH + TKEEP_WIDTH + 1
);
  logic                   rx_axis_resetn;
  logic [MAC_WIDTH-1:0]   rx_axis_tdata;
  logic [TKEEP_WIDTH-1:0] rx_axis_tkeep;
  logic                   rx_axis_tvalid;
  logic                   rx_axis_tuser;
  logic                   rx_axis_tlast;
  logic [NIC_WIDTH-1:0]   RX_FIFO_pipe_read_data;
  logic                   RX_FIFO_pipe_read_req;
  logic                   RX_FIFO_pipe_read_ack;

  // Pipe handshake: a word moves on a posedge where read_ack=1 and read_req=1;
  // while read_ack=1 and no transfer happens, read_data holds its value.
  // The AXI-Stream side has no tready: every tvalid beat is consumed or dropped.
  modport master (
    input  rx_axis_resetn,
    output rx_axis_tdata,
    output rx_axis_tkeep,
    output rx_axis_tvalid,
    output rx_axis_tuser,
    output rx_axis_tlast,
    input  RX_FIFO_pipe_read_data,
    output RX_FIFO_pipe_read_req,
    input  RX_FIFO_pipe_read_ack
  );

  modport slave (
    output rx_axis_resetn,
    input  rx_axis_tdata,
    input  rx_axis_tkeep,
    input  rx_axis_tvalid,
    input  rx_axis_tuser,
    input  rx_axis_tlast,
    output RX_FIFO_pipe_read_data,
    input  RX_FIFO_pipe_read_req,
    output RX_FIFO_pipe_read_ack
  );
endinterface

// File: rtl/mac_rx_frame_buffer.sv
// Store-and-forward RX frame buffer: frames become readable only after a good-FCS tlast;
// bad, oversize and overflowed frames are removed by rewinding the speculative write pointer.
module mac_rx_frame_buffer #(
  parameter int MAC_WIDTH       = 64,
  parameter int TKEEP_WIDTH     = 8,
  parameter int NIC_WIDTH       = MAC_WIDTH + TKEEP_WIDTH + 1,
  parameter int DEPTH_LOG2      = 9,
  parameter int MAX_FRAME_WORDS = 190,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mac_rx_frame_buffer_if.slave bus,
  output logic [CNT_WIDTH-1:0] frames_committed,
  output logic [CNT_WIDTH-1:0] drop_bad_fcs,
  output logic [CNT_WIDTH-1:0] drop_overflow,
  output logic [CNT_WIDTH-1:0] drop_oversize,
  output logic [1:0]           dbg_wr_state
);

  localparam int AW    = DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = $clog2(MAX_FRAME_WORDS + 1);

  localparam logic [PW-1:0] FULL_LEVEL = {1'b1, {AW{1'b0}}};
  localparam logic [CW-1:0] MAX_W      = CW'(MAX_FRAME_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [NIC_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  commit_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [1:0]     state;
  logic [CW-1:0]  word_cnt;

  logic           beat;
  logic           full;
  logic           in_frame;
  logic [CW-1:0]  cnt_nxt;
  logic           wr_en;
  logic [NIC_WIDTH-1:0] wr_word;
  logic           readable;
  logic           xfer;
  logic           load;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // full uses rd_ptr before this cycle's read, so it is conservative by one word
  always_comb begin
    beat     = bus.rx_axis_tvalid;
    full     = (wr_ptr - rd_ptr) == FULL_LEVEL;
    in_frame = (state != ST_DROP);
    cnt_nxt  = (state == ST_RECV) ? word_cnt + CW'(1) : CW'(1);
    wr_en    = beat && in_frame && !full && !reset;
    wr_word  = {bus.rx_axis_tlast, bus.rx_axis_tdata, bus.rx_axis_tkeep};
    readable = (rd_ptr != commit_ptr);
    xfer     = bus.RX_FIFO_pipe_read_ack && bus.RX_FIFO_pipe_read_req;
    load     = readable && (!bus.RX_FIFO_pipe_read_ack || bus.RX_FIFO_pipe_read_req);
  end

  assign dbg_wr_state = state;

  always_ff @(posedge clk) begin
    bus.rx_axis_resetn <= !reset;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_word;
    end
  end

  // Write FSM. IDLE and RECV share the rules; in IDLE wr_ptr equals commit_ptr,
  // so a rewind there (including a single-word oversize beat) leaves nothing behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      commit_ptr       <= '0;
      state            <= ST_IDLE;
      word_cnt         <= '0;
      frames_committed <= '0;
      drop_bad_fcs     <= '0;
      drop_overflow    <= '0;
      drop_oversize    <= '0;
    end else if (beat) begin
      case (state)
        ST_DROP: begin
          if (bus.rx_axis_tlast) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          if (full) begin
            wr_ptr        <= commit_ptr;
            drop_overflow <= sat_inc(drop_overflow);
            state         <= bus.rx_axis_tlast ? ST_IDLE : ST_DROP;
          end else if (bus.rx_axis_tlast) begin
            if (bus.rx_axis_tuser) begin
              wr_ptr           <= wr_ptr + PW'(1);
              commit_ptr       <= wr_ptr + PW'(1);
              frames_committed <= sat_inc(frames_committed);
            end else begin
              wr_ptr       <= commit_ptr;
              drop_bad_fcs <= sat_inc(drop_bad_fcs);
            end
            state <= ST_IDLE;
          end else if (cnt_nxt == MAX_W) begin
            wr_ptr        <= commit_ptr;
            drop_oversize <= sat_inc(drop_oversize);
            state         <= ST_DROP;
          end else begin
            wr_ptr   <= wr_ptr + PW'(1);
            word_cnt <= cnt_nxt;
            state    <= ST_RECV;
          end
        end
      endcase
    end
  end

  // Show-ahead output stage; read_data is the registered memory read itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr                     <= '0;
      bus.RX_FIFO_pipe_read_ack  <= 1'b0;
      bus.RX_FIFO_pipe_read_data <= '0;
    end else if (load) begin
      bus.RX_FIFO_pipe_read_data <= mem[rd_ptr[AW-1:0]];
      rd_ptr                     <= rd_ptr + PW'(1);
      bus.RX_FIFO_pipe_read_ack  <= 1'b1;
    end else if (xfer) begin
      bus.RX_FIFO_pipe_read_ack  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_rx_frame_buffer.sv
// Directed bench for mac_rx_frame_buffer: frames in, expected pipe words through a scoreboard queue.
module tb_mac_rx_frame_buffer;
  localparam int MAC_WIDTH       = 64;
  localparam int TKEEP_WIDTH     = 8;
  localparam int NIC_WIDTH       = MAC_WIDTH + TKEEP_WIDTH + 1;
  localparam int DEPTH_LOG2      = 3;
  localparam int MAX_FRAME_WORDS = 6;
  localparam int CNT_WIDTH       = 16;
  localparam int W               = NIC_WIDTH;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_rx_frame_buffer_if #(
    .MAC_WIDTH(MAC_WIDTH), .TKEEP_WIDTH(TKEEP_WIDTH), .NIC_WIDTH(NIC_WIDTH)
  ) bus ();

  logic [CNT_WIDTH-1:0] frames_committed;
  logic [CNT_WIDTH-1:0] drop_bad_fcs;
  logic [CNT_WIDTH-1:0] drop_overflow;
  logic [CNT_WIDTH-1:0] drop_oversize;
  logic [1:0]           dbg_wr_state;

  mac_rx_frame_buffer #(
    .MAC_WIDTH(MAC_WIDTH), .TKEEP_WIDTH(TKEEP_WIDTH), .NIC_WIDTH(NIC_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2), .MAX_FRAME_WORDS(MAX_FRAME_WORDS), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .frames_committed(frames_committed),
    .drop_bad_fcs(drop_bad_fcs),
    .drop_overflow(drop_overflow),
    .drop_oversize(drop_oversize),
    .dbg_wr_state(dbg_wr_state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int exp_committed = 0;
  int exp_bad_fcs   = 0;
  int exp_overflow  = 0;
  int exp_oversize  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every cycle the DUT shows a word it must equal the queue head; pop on transfer
  always @(negedge clk) begin
    if (bus.RX_FIFO_pipe_read_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %h expected no word", bus.RX_FIFO_pipe_read_data);
      end else begin
        check("read_data", bus.RX_FIFO_pipe_read_data, exp_q[0]);
        if (bus.RX_FIFO_pipe_read_req === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  // driver tasks; every task starts and ends 1 time unit after a posedge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_beat(input logic [MAC_WIDTH-1:0] d, input logic [TKEEP_WIDTH-1:0] k,
                            input logic last, input logic user);
    bus.rx_axis_tvalid = 1'b1;
    bus.rx_axis_tdata  = d;
    bus.rx_axis_tkeep  = k;
    bus.rx_axis_tlast  = last;
    bus.rx_axis_tuser  = user;
    tick(1);
    bus.rx_axis_tvalid = 1'b0;
    bus.rx_axis_tlast  = 1'b0;
    bus.rx_axis_tuser  = 1'b0;
  endtask

  // beat i carries byte (b + s*i) in every lane; expect_out pushes the words it should deliver
  task automatic send_frame(input int n, input logic good, input logic [TKEEP_WIDTH-1:0] last_keep,
                            input int b, input int s, input logic expect_out);
    for (int i = 0; i < n; i++) begin
      logic [7:0]             byt;
      logic [MAC_WIDTH-1:0]   d;
      logic [TKEEP_WIDTH-1:0] k;
      logic                   last;
      byt  = 8'(b + s * i);
      d    = {8{byt}};
      last = (i == n - 1);
      k    = last ? last_keep : 8'hFF;
      if (expect_out) exp_q.push_back({last, d, k});
      drive_beat(d, k, last, last ? good : 1'b0);
    end
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      tick(1);
      cyc++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d words left expected 0", name, exp_q.size());
      exp_q.delete();
    end
    tick(3);
  endtask

  task automatic check_counters(input string name);
    check({name, "_committed"}, W'(frames_committed), W'(CNT_WIDTH'(exp_committed)));
    check({name, "_bad_fcs"},   W'(drop_bad_fcs),     W'(CNT_WIDTH'(exp_bad_fcs)));
    check({name, "_overflow"},  W'(drop_overflow),    W'(CNT_WIDTH'(exp_overflow)));
    check({name, "_oversize"},  W'(drop_oversize),    W'(CNT_WIDTH'(exp_oversize)));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset                     = 1'b1;
    bus.rx_axis_tvalid        = 1'b0;
    bus.rx_axis_tdata         = '0;
    bus.rx_axis_tkeep         = '0;
    bus.rx_axis_tlast         = 1'b0;
    bus.rx_axis_tuser         = 1'b0;
    bus.RX_FIFO_pipe_read_req = 1'b0;
    tick(2);
    @(negedge clk);
    check("reset_resetn", W'(bus.rx_axis_resetn), W'(1'b0));
    check("reset_ack", W'(bus.RX_FIFO_pipe_read_ack), W'(1'b0));
    check("reset_data", bus.RX_FIFO_pipe_read_data, '0);
    check("reset_state", W'(dbg_wr_state), W'(2'd0));
    check_counters("reset");
    tick(1);
    reset = 1'b0;
    tick(2);
    check("run_resetn", W'(bus.rx_axis_resetn), W'(1'b1));

    // single 3-beat good frame, hand-written expected words
    bus.RX_FIFO_pipe_read_req = 1'b1;
    exp_q.push_back({1'b0, 64'h1111_1111_1111_1111, 8'hFF});
    exp_q.push_back({1'b0, 64'h2222_2222_2222_2222, 8'hFF});
    exp_q.push_back({1'b1, 64'h3333_3333_3333_3333, 8'h0F});
    send_frame(3, 1'b1, 8'h0F, 'h11, 'h11, 1'b0);
    wait_drain("t1");
    exp_committed = 1;
    check_counters("t1");

    // good, bad-FCS, good: the bad frame never appears
    send_frame(2, 1'b1, 8'h3F, 'h21, 1, 1'b1);
    send_frame(4, 1'b0, 8'hFF, 'h31, 1, 1'b0);
    send_frame(1, 1'b1, 8'h01, 'h41, 1, 1'b1);
    wait_drain("t2");
    exp_committed = 3;
    exp_bad_fcs   = 1;
    check_counters("t2");

    // backpressure: hold, then req 1,0,1,1
    bus.RX_FIFO_pipe_read_req = 1'b0;
    send_frame(4, 1'b1, 8'h07, 'h51, 1, 1'b1);
    tick(4);
    bus.RX_FIFO_pipe_read_req = 1'b1;
    tick(1);
    bus.RX_FIFO_pipe_read_req = 1'b0;
    tick(1);
    bus.RX_FIFO_pipe_read_req = 1'b1;
    wait_drain("t3");
    exp_committed = 4;
    check_counters("t3");

    // overflow: 6-word frame fills an 8-word buffer, the next frame cannot fit
    bus.RX_FIFO_pipe_read_req = 1'b0;
    send_frame(6, 1'b1, 8'hFF, 'h61, 1, 1'b1);
    send_frame(4, 1'b1, 8'hFF, 'h71, 1, 1'b0);
    tick(3);
    exp_committed = 5;
    exp_overflow  = 1;
    check_counters("t4");
    bus.RX_FIFO_pipe_read_req = 1'b1;
    wait_drain("t4");
    send_frame(6, 1'b1, 8'h0F, 'h81, 1, 1'b1);
    wait_drain("t4_wrap_a");
    send_frame(5, 1'b1, 8'h7F, 'h91, 1, 1'b1);
    wait_drain("t4_wrap_b");
    exp_committed = 7;
    check_counters("t4_wrap");

    // oversize: 8 beats exceed 6 words, the following 2-beat frame survives
    send_frame(8, 1'b1, 8'hFF, 'hA1, 1, 1'b0);
    send_frame(2, 1'b1, 8'h03, 'hB1, 1, 1'b1);
    wait_drain("t5");
    exp_committed = 8;
    exp_oversize  = 1;
    check_counters("t5");

    // reset on beat 2 of a 5-beat frame with one frame buffered
    bus.RX_FIFO_pipe_read_req = 1'b0;
    send_frame(2, 1'b1, 8'h1F, 'hC1, 1, 1'b1);
    tick(3);
    drive_beat({8{8'hE1}}, 8'hFF, 1'b0, 1'b0);
    bus.rx_axis_tvalid = 1'b1;
    bus.rx_axis_tdata  = {8{8'hE2}};
    bus.rx_axis_tkeep  = 8'hFF;
    reset              = 1'b1;
    tick(1);
    exp_q.delete();
    bus.rx_axis_tvalid = 1'b0;
    exp_committed = 0;
    exp_bad_fcs   = 0;
    exp_overflow  = 0;
    exp_oversize  = 0;
    @(negedge clk);
    check("t6_resetn", W'(bus.rx_axis_resetn), W'(1'b0));
    check("t6_ack", W'(bus.RX_FIFO_pipe_read_ack), W'(1'b0));
    check_counters("t6_reset");
    tick(1);
    reset = 1'b0;
    tick(4);
    check("t6_resetn_release", W'(bus.rx_axis_resetn), W'(1'b1));
    check("t6_empty_ack", W'(bus.RX_FIFO_pipe_read_ack), W'(1'b0));
    bus.RX_FIFO_pipe_read_req = 1'b1;
    send_frame(3, 1'b1, 8'h3F, 'hD1, 1, 1'b1);
    wait_drain("t6");
    exp_committed = 1;
    check_counters("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
